// File: rtl/seq_div16_pkg.sv
// rtl/seq_div16_pkg.sv - shared types, widths and helpers for the seq_div16 divider
package seq_div16_pkg;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;
    localparam logic [WIDTH-1:0] DIV0_QUOT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Two's-complement magnitude; -32768 maps to 16'h8000, read as unsigned.
    function automatic logic [WIDTH-1:0] abs16(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (16'd0 - v) : v;
    endfunction

endpackage

// File: rtl/addsub17.sv
// rtl/addsub17.sv - 17-bit a + ~b + 1 subtract built from generate/propagate carry cells
module addsub17 (
    input  logic [16:0] a,
    input  logic [16:0] b,
    output logic [16:0] diff,
    output logic        neg
);

    logic [16:0] bn;
    logic [16:0] g;
    logic [16:0] p;

    assign bn = ~b;
    assign g  = a & bn;
    assign p  = a ^ bn;

    // Carry chain seeded with 1 (the +1 of the two's-complement subtract).
    always_comb begin
        logic c;
        c    = 1'b1;
        diff = '0;
        for (int i = 0; i < 17; i++) begin
            diff[i] = p[i] ^ c;
            c       = g[i] | (p[i] & c);
        end
    end

    assign neg = diff[16];

endmodule

// File: rtl/seq_div16.sv
// rtl/seq_div16.sv - iterative 16-bit restoring divider; SIGNED_DIV_EN selects two's-complement operation
module seq_div16
    import seq_div16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [15:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero
);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   q_reg;
    logic [WIDTH:0]     r_reg;
    logic [WIDTH-1:0]   dsr;
    logic [CNT_W-1:0]   cnt;

    logic [WIDTH:0]     r_shift;
    logic [WIDTH:0]     d;
    logic               d_neg;
    logic [WIDTH-1:0]   q_step;
    logic [WIDTH:0]     r_step;

`ifdef SIGNED_DIV_EN
    logic               neg_q;
    logic               neg_r;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // One restoring step: shift the next dividend bit into R and try subtracting the divisor.
    assign r_shift = {r_reg[WIDTH-1:0], q_reg[WIDTH-1]};

    addsub17 u_sub (
        .a    (r_shift),
        .b    ({1'b0, dsr}),
        .diff (d),
        .neg  (d_neg)
    );

    assign q_step = {q_reg[WIDTH-2:0], ~d_neg};
    assign r_step = d_neg ? r_shift : d;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = (divisor == '0) ? DONE : CALC;
`ifdef SIGNED_DIV_EN
            CALC: if (cnt == '0) state_nxt = FIX;
            FIX:  state_nxt = DONE;
`else
            CALC: if (cnt == '0) state_nxt = DONE;
`endif
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration registers and the held result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_reg       <= '0;
            r_reg       <= '0;
            dsr         <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        r_reg <= '0;
                        cnt   <= CNT_W'(WIDTH - 1);
`ifdef SIGNED_DIV_EN
                        q_reg <= abs16(dividend);
                        dsr   <= abs16(divisor);
                        neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_r <= dividend[WIDTH-1];
`else
                        q_reg <= dividend;
                        dsr   <= divisor;
`endif
                        if (divisor == '0) begin
                            quotient    <= DIV0_QUOT;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    q_reg <= q_step;
                    r_reg <= r_step;
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
`ifndef SIGNED_DIV_EN
                    else begin
                        quotient  <= q_step;
                        remainder <= r_step[WIDTH-1:0];
                    end
`endif
                end
`ifdef SIGNED_DIV_EN
                FIX: begin
                    quotient  <= neg_q ? (16'd0 - q_reg) : q_reg;
                    remainder <= neg_r ? (16'd0 - r_reg[WIDTH-1:0]) : r_reg[WIDTH-1:0];
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
